// File: rtl/ioctl_loader_pkg.sv
// ---------------------------------------------------------------------------
// ioctl_loader_pkg
// Shared types and constants for the ioctl ROM loader:
//   wr_entry_t       - one 16-bit SDRAM write request (word address, byte
//                      selects, data)
//   state_t          - download tracking state
//   BG_BASE_DEFAULT  - first byte address of the sprite/background region
//   p2_word_addr()   - remap of a sprite-region byte offset so the two
//                      sprite ROMs interleave into 32-bit words
// ---------------------------------------------------------------------------
package ioctl_loader_pkg;

  typedef struct packed {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } wr_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  localparam logic [24:0] BG_BASE_DEFAULT = 25'h0A000;

  // Bit 14 of the offset selects the sprite ROM and becomes the low word
  // address bit; bit 13 picks the byte lane, so the 8 KB halves of each ROM
  // land side by side in one 16-bit word.
  function automatic logic [22:0] p2_word_addr(input logic [23:0] b);
    return {b[23:15], b[12:0], b[14]};
  endfunction

endpackage

// File: rtl/loader_port_fifo.sv
// ---------------------------------------------------------------------------
// loader_port_fifo
// Small FIFO of SDRAM write entries followed by a toggle-handshake issuer.
// A request is outstanding while o_req != i_ack; when nothing is outstanding
// and the FIFO holds data, the head is loaded into the output registers,
// popped, and o_req toggles in the same cycle.
// Ports:
//   clk_sys, reset        clock, asynchronous active-high reset (flushes)
//   i_push, i_a/i_ds/i_d  entry to enqueue
//   i_ack                 toggle acknowledge from the SDRAM controller
//   o_req                 toggle request
//   o_a/o_ds/o_d          request payload, stable while outstanding
//   o_drop                push refused because the FIFO was full
//   o_idle                FIFO empty and no request outstanding
// ---------------------------------------------------------------------------
module loader_port_fifo
  import ioctl_loader_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        i_push,
  input  logic [22:0] i_a,
  input  logic [1:0]  i_ds,
  input  logic [15:0] i_d,
  input  logic        i_ack,
  output logic        o_req,
  output logic [22:0] o_a,
  output logic [1:0]  o_ds,
  output logic [15:0] o_d,
  output logic        o_drop,
  output logic        o_idle
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  wr_entry_t       r_mem [DEPTH];
  logic [AW:0]     r_wr_ptr;
  logic [AW:0]     r_rd_ptr;
  logic            r_req;
  wr_entry_t       r_out;

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_wr_en;
  wr_entry_t       w_in;
  wr_entry_t       w_head;

  assign w_in    = '{a: i_a, ds: i_ds, d: i_d};
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  assign w_pop   = (r_req == i_ack) && !w_empty;
  // A full FIFO that pops this cycle frees the slot being written.
  assign w_wr_en = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;
  assign o_idle  = w_empty && (r_req == i_ack);

  // NOTE: the storage array has no reset; clearing the pointers flushes it,
  // and leaving it out of reset lets it map onto plain RAM/LUT storage.
  always_ff @(posedge clk_sys) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= w_in;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_req    <= 1'b0;
      r_out    <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_out    <= w_head;
        r_req    <= ~r_req;
      end
    end
  end

  assign o_req = r_req;
  assign o_a   = r_out.a;
  assign o_ds  = r_out.ds;
  assign o_d   = r_out.d;

endmodule

// File: rtl/ioctl_rom_loader.sv
// ---------------------------------------------------------------------------
// ioctl_rom_loader
// Converts the byte-wide data_io download stream into 16-bit toggle-handshake
// SDRAM writes. Port1 receives the whole image; port2 receives only bytes at
// or above BG_BASE, remapped so the two sprite ROMs merge into 32-bit words.
// Tracks download completion, drives rom_loaded and the core reset.
// Ports:
//   clk_sys, reset                 clock, asynchronous active-high reset
//   ioctl_downl/index/wr/addr/dout data_io download interface
//   reset_req                      external core reset request
//   port{1,2}_req/ack/a/ds/we/d    SDRAM write ports (toggle handshake)
//   rom_loaded                     image complete and fully written
//   core_reset                     reset_req | ~rom_loaded, registered
//   byte_count                     accepted bytes in the current download
//   overflow                       sticky: a byte was dropped (FIFO full)
// ---------------------------------------------------------------------------
module ioctl_rom_loader
  import ioctl_loader_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX  = 8'd0,
  parameter logic [24:0] BG_BASE    = BG_BASE_DEFAULT,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_downl,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        reset_req,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic        port1_we,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic        port2_we,
  output logic [15:0] port2_d,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic [24:0] byte_count,
  output logic        overflow
);

  state_t      r_state;
  logic        r_wr;
  logic        r_downl;
  logic        r_we;
  logic        r_rom_loaded;
  logic        r_core_reset;
  logic [24:0] r_byte_count;
  logic        r_overflow;

  logic        w_index_ok;
  logic        w_start;
  logic        w_fall;
  logic        w_accept;
  logic        w_p2_hit;
  logic [23:0] w_b;
  logic        w_drop1;
  logic        w_drop2;
  logic        w_idle1;
  logic        w_idle2;

  assign w_index_ok = (ioctl_index == ROM_INDEX);
  assign w_start    = ioctl_downl && !r_downl && w_index_ok;
  assign w_fall     = !ioctl_downl && r_downl;
  assign w_accept   = (r_state == LOAD) && ioctl_downl && w_index_ok &&
                      ioctl_wr && !r_wr;

  // Only the low 24 bits of the offset are ever used, so the subtraction is
  // done at that width; the compare still sees the full 25-bit address.
  assign w_p2_hit   = (ioctl_addr >= BG_BASE);
  assign w_b        = ioctl_addr[23:0] - BG_BASE[23:0];

  loader_port_fifo #(.DEPTH(FIFO_DEPTH)) u_port1 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_push  (w_accept),
    .i_a     (ioctl_addr[23:1]),
    .i_ds    ({ioctl_addr[0], ~ioctl_addr[0]}),
    .i_d     ({ioctl_dout, ioctl_dout}),
    .i_ack   (port1_ack),
    .o_req   (port1_req),
    .o_a     (port1_a),
    .o_ds    (port1_ds),
    .o_d     (port1_d),
    .o_drop  (w_drop1),
    .o_idle  (w_idle1)
  );

  loader_port_fifo #(.DEPTH(FIFO_DEPTH)) u_port2 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .i_push  (w_accept && w_p2_hit),
    .i_a     (p2_word_addr(w_b)),
    .i_ds    ({w_b[13], ~w_b[13]}),
    .i_d     ({ioctl_dout, ioctl_dout}),
    .i_ack   (port2_ack),
    .o_req   (port2_req),
    .o_a     (port2_a),
    .o_ds    (port2_ds),
    .o_d     (port2_d),
    .o_drop  (w_drop2),
    .o_idle  (w_idle2)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_wr         <= 1'b0;
      // Treat downl as already high so a download still in progress when
      // reset drops is not mistaken for a fresh start.
      r_downl      <= 1'b1;
      r_we         <= 1'b0;
      r_rom_loaded <= 1'b0;
      r_core_reset <= 1'b1;
      r_byte_count <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_wr         <= ioctl_wr;
      r_downl      <= ioctl_downl;
      r_core_reset <= reset_req | ~r_rom_loaded;

      if (w_accept)          r_byte_count <= r_byte_count + 25'd1;
      if (w_drop1 | w_drop2) r_overflow   <= 1'b1;

      case (r_state)
        IDLE, DONE: begin
          if (w_start) begin
            r_state      <= LOAD;
            r_we         <= 1'b1;
            r_rom_loaded <= 1'b0;
            r_byte_count <= '0;
            r_overflow   <= 1'b0;
          end
        end
        LOAD: begin
          if (w_fall) r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_idle1 && w_idle2) begin
            r_state      <= DONE;
            r_we         <= 1'b0;
            r_rom_loaded <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign port1_we   = r_we;
  assign port2_we   = r_we;
  assign rom_loaded = r_rom_loaded;
  assign core_reset = r_core_reset;
  assign byte_count = r_byte_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// ---------------------------------------------------------------------------
// tb_ioctl_rom_loader
// Directed, self-checking bench for ioctl_rom_loader. A negedge responder
// acknowledges each port after a programmable delay (or holds off), and a
// monitor records every request toggle with its payload.
// ---------------------------------------------------------------------------
module tb_ioctl_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_downl = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        reset_req = 1'b0;
  logic        port1_req, port2_req;
  logic        port1_ack = 1'b0, port2_ack = 1'b0;
  logic [22:0] port1_a, port2_a;
  logic [1:0]  port1_ds, port2_ds;
  logic        port1_we, port2_we;
  logic [15:0] port1_d, port2_d;
  logic        rom_loaded, core_reset, overflow;
  logic [24:0] byte_count;

  always #5 clk_sys = ~clk_sys;

  ioctl_rom_loader dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_downl(ioctl_downl), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .reset_req(reset_req),
    .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
    .port1_ds(port1_ds), .port1_we(port1_we), .port1_d(port1_d),
    .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
    .port2_ds(port2_ds), .port2_we(port2_we), .port2_d(port2_d),
    .rom_loaded(rom_loaded), .core_reset(core_reset),
    .byte_count(byte_count), .overflow(overflow)
  );

  typedef struct {
    logic [22:0] a;
    logic [1:0]  ds;
    logic [15:0] d;
  } ent_t;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  dout;
    logic [22:0] p1_a;
    logic [1:0]  p1_ds;
    logic        p2_hit;
    logic [22:0] p2_a;
    logic [1:0]  p2_ds;
  } vec_t;

  ent_t q1[$];
  ent_t q2[$];
  ent_t cur1, cur2;
  logic prev1 = 1'b0, prev2 = 1'b0;
  int   cnt1 = 0, cnt2 = 0;
  int   ack_delay = 1;
  logic hold1 = 1'b0, hold2 = 1'b0;
  int   stable_err = 0;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Responder and monitor: both act on the falling edge, away from the DUT.
  always @(negedge clk_sys) begin
    if (reset) begin
      port1_ack = 1'b0; port2_ack = 1'b0;
      cnt1 = 0; cnt2 = 0;
      prev1 = port1_req; prev2 = port2_req;
    end else begin
      if (port1_req != prev1) begin
        cur1 = '{port1_a, port1_ds, port1_d};
        q1.push_back(cur1);
        prev1 = port1_req;
      end else if (port1_req != port1_ack &&
                   (port1_a != cur1.a || port1_ds != cur1.ds || port1_d != cur1.d))
        stable_err++;
      if (port2_req != prev2) begin
        cur2 = '{port2_a, port2_ds, port2_d};
        q2.push_back(cur2);
        prev2 = port2_req;
      end else if (port2_req != port2_ack &&
                   (port2_a != cur2.a || port2_ds != cur2.ds || port2_d != cur2.d))
        stable_err++;
      if (port1_req != port1_ack) begin
        cnt1++;
        if (cnt1 >= ack_delay && !hold1) begin port1_ack = port1_req; cnt1 = 0; end
      end
      if (port2_req != port2_ack) begin
        cnt2++;
        if (cnt2 >= ack_delay && !hold2) begin port2_ack = port2_req; cnt2 = 0; end
      end
    end
  end

  task automatic strobe(input logic [24:0] a, input logic [7:0] d, input int gap);
    @(negedge clk_sys);
    ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic start_download(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index = idx; ioctl_downl = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic wait_loaded(input int budget, output logic seen);
    seen = rom_loaded;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk_sys);
      seen = rom_loaded;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];
  logic seen;
  int   errs;
  logic [24:0] ea;
  logic [23:0] eb;
  logic [7:0]  ed;
  logic [22:0] exp_a;

  initial begin
    vecs[0] = '{25'h0E005, 8'h3C, 23'h007002, 2'b10, 1'b1, 23'h00000B, 2'b01};
    vecs[1] = '{25'h0A000, 8'h11, 23'h005000, 2'b01, 1'b1, 23'h000000, 2'b01};
    vecs[2] = '{25'h09FFF, 8'h22, 23'h004FFF, 2'b10, 1'b0, 23'h000000, 2'b00};
    vecs[3] = '{25'h0C000, 8'h5A, 23'h006000, 2'b01, 1'b1, 23'h000000, 2'b10};
    vecs[4] = '{25'h12001, 8'h96, 23'h009000, 2'b10, 1'b1, 23'h004002, 2'b01};
    vecs[5] = '{25'h0A001, 8'h7E, 23'h005000, 2'b10, 1'b1, 23'h000002, 2'b01};

    // ---- reset state
    repeat (3) @(negedge clk_sys);
    check("rst_core_reset", core_reset, 1);
    check("rst_rom_loaded", rom_loaded, 0);
    check("rst_req1", port1_req, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_we", port1_we, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    // ---- download start, single byte with 3-cycle ack
    start_download(8'd0);
    check("load_we", port1_we, 1);
    check("load_rom_loaded", rom_loaded, 0);
    ack_delay = 3;
    q1.delete(); q2.delete();
    ioctl_addr = 25'h00001; ioctl_dout = 8'hA5; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("single_req_n1", port1_req, 0);
    @(negedge clk_sys);
    check("single_req_n2", port1_req, 1);
    check("single_a", port1_a, 0);
    check("single_ds", port1_ds, 2'b10);
    check("single_d", port1_d, 16'hA5A5);
    repeat (6) @(negedge clk_sys);
    check("single_acked", port1_ack, 1);
    check("single_p2_silent", q2.size(), 0);
    check("single_count", byte_count, 1);

    // ---- table-driven mapping vectors
    ack_delay = 1;
    foreach (vecs[i]) begin
      q1.delete(); q2.delete();
      strobe(vecs[i].addr, vecs[i].dout, 0);
      repeat (4) @(negedge clk_sys);
      check($sformatf("vec%0d_p1_n", i), q1.size(), 1);
      if (q1.size() > 0) begin
        check($sformatf("vec%0d_p1_a", i), q1[0].a, vecs[i].p1_a);
        check($sformatf("vec%0d_p1_ds", i), q1[0].ds, vecs[i].p1_ds);
        check($sformatf("vec%0d_p1_d", i), q1[0].d, {vecs[i].dout, vecs[i].dout});
      end
      check($sformatf("vec%0d_p2_n", i), q2.size(), vecs[i].p2_hit);
      if (vecs[i].p2_hit && q2.size() > 0) begin
        check($sformatf("vec%0d_p2_a", i), q2[0].a, vecs[i].p2_a);
        check($sformatf("vec%0d_p2_ds", i), q2[0].ds, vecs[i].p2_ds);
        check($sformatf("vec%0d_p2_d", i), q2[0].d, {vecs[i].dout, vecs[i].dout});
      end
    end
    check("table_count", byte_count, 7);

    // ---- stall: ack held, 6 strobes into 1 outstanding + 4 FIFO slots
    hold1 = 1'b1;
    q1.delete();
    for (int i = 0; i < 6; i++) begin
      strobe(25'h00100 + 25'(i), 8'hC0 + 8'(i), 1);
      if (i == 4) check("stall_no_ovf_5", overflow, 0);
      if (i == 5) check("stall_ovf_6", overflow, 1);
    end
    check("stall_one_issued", q1.size(), 1);
    repeat (30) @(negedge clk_sys);
    hold1 = 1'b0;
    repeat (20) @(negedge clk_sys);
    check("stall_delivered", q1.size(), 5);
    for (int i = 0; i < 5 && i < q1.size(); i++) begin
      check($sformatf("stall_e%0d_a", i), q1[i].a, 23'h80 + 23'(i / 2));
      check($sformatf("stall_e%0d_d", i), q1[i].d, {8'hC0 + 8'(i), 8'hC0 + 8'(i)});
    end
    check("stall_count", byte_count, 13);
    check("stall_ovf_sticky", overflow, 1);

    // ---- finish first download
    ioctl_downl = 1'b0;
    wait_loaded(50, seen);
    check("dl1_done", seen, 1);

    // ---- completion with pending entries at the downl fall
    start_download(8'd0);
    check("cmp_ovf_cleared", overflow, 0);
    check("cmp_count_cleared", byte_count, 0);
    q1.delete(); q2.delete();
    for (int i = 0; i < 'h1FE; i++) begin
      ea = 25'h09F00 + 25'(i);
      strobe(ea, ea[7:0] ^ 8'h5A, 0);
    end
    repeat (3) @(negedge clk_sys);
    hold1 = 1'b1; hold2 = 1'b1;
    for (int i = 'h1FE; i < 'h200; i++) begin
      ea = 25'h09F00 + 25'(i);
      strobe(ea, ea[7:0] ^ 8'h5A, 0);
    end
    repeat (2) @(negedge clk_sys);
    ioctl_downl = 1'b0;
    repeat (5) @(negedge clk_sys);
    check("drain_we", port1_we, 1);
    check("drain_not_loaded", rom_loaded, 0);
    check("drain_pending", port1_req != port1_ack, 1);
    hold1 = 1'b0; hold2 = 1'b0;
    wait_loaded(40, seen);
    check("drain_done", seen, 1);
    check("core_reset_lag", core_reset, 1);
    @(negedge clk_sys);
    check("core_reset_released", core_reset, 0);
    check("cmp_count", byte_count, 25'h200);
    check("cmp_we_off", port1_we, 0);
    check("cmp_no_ovf", overflow, 0);
    check("cmp_p1_n", q1.size(), 'h200);
    check("cmp_p2_n", q2.size(), 'h100);
    errs = 0;
    for (int k = 0; k < q1.size(); k++) begin
      ea = 25'h09F00 + 25'(k);
      ed = ea[7:0] ^ 8'h5A;
      if (q1[k].a != ea[23:1] || q1[k].ds != {ea[0], ~ea[0]} || q1[k].d != {ed, ed})
        errs++;
    end
    check("cmp_p1_content", errs, 0);
    errs = 0;
    for (int k = 0; k < q2.size(); k++) begin
      eb = 24'(k);
      ea = 25'h0A000 + 25'(k);
      ed = ea[7:0] ^ 8'h5A;
      exp_a = 23'((eb >> 15) << 14) | 23'((eb & 24'h1FFF) << 1) | 23'((eb >> 14) & 24'h1);
      if (q2[k].a != exp_a || q2[k].ds != {eb[13], ~eb[13]} || q2[k].d != {ed, ed})
        errs++;
    end
    check("cmp_p2_content", errs, 0);

    // ---- foreign index download is ignored
    q1.delete(); q2.delete();
    start_download(8'd1);
    for (int i = 0; i < 3; i++) strobe(25'h0E000 + 25'(i), 8'h44, 1);
    ioctl_downl = 1'b0;
    repeat (4) @(negedge clk_sys);
    check("idx_rom_loaded", rom_loaded, 1);
    check("idx_we", port1_we, 0);
    check("idx_p1_silent", q1.size(), 0);
    check("idx_p2_silent", q2.size(), 0);
    check("idx_count", byte_count, 25'h200);

    // ---- redownload clears status at LOAD entry
    start_download(8'd0);
    check("redl_rom_loaded", rom_loaded, 0);
    check("redl_count", byte_count, 0);
    check("redl_we", port1_we, 1);
    check("redl_core_reset", core_reset, 1);

    // ---- async reset mid-LOAD
    hold1 = 1'b1;
    strobe(25'h00003, 8'h77, 1);
    check("prerst_req1", port1_req, 1);
    check("prerst_req2", port2_req, 1);
    check("prerst_count", byte_count, 1);
    #2 reset = 1'b1;
    #1;
    check("arst_req1", port1_req, 0);
    check("arst_req2", port2_req, 0);
    check("arst_rom_loaded", rom_loaded, 0);
    check("arst_core_reset", core_reset, 1);
    check("arst_count", byte_count, 0);
    check("arst_we", port1_we, 0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset = 1'b0;
    hold1 = 1'b0;
    q1.delete(); q2.delete();
    strobe(25'h00004, 8'h55, 1);
    strobe(25'h0B000, 8'h66, 1);
    repeat (3) @(negedge clk_sys);
    check("postrst_ignored_count", byte_count, 0);
    check("postrst_p1_silent", q1.size(), 0);
    check("postrst_p2_silent", q2.size(), 0);
    check("postrst_idle_we", port1_we, 0);
    ioctl_downl = 1'b0;
    repeat (3) @(negedge clk_sys);
    start_download(8'd0);
    strobe(25'h00005, 8'h99, 1);
    repeat (4) @(negedge clk_sys);
    check("newdl_count", byte_count, 1);
    check("newdl_p1_n", q1.size(), 1);
    if (q1.size() > 0) begin
      check("newdl_a", q1[0].a, 23'h2);
      check("newdl_ds", q1[0].ds, 2'b10);
      check("newdl_d", q1[0].d, 16'h9999);
    end

    check("payload_stable", stable_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
